// File: rtl/uart_periph.sv
// uart_periph: APB slave UART with a small TX FIFO, a single-byte RX holding
// register, overrun/framing flags and a programmable bit-period divisor.
module uart_periph #(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] DIV_RESET  = 16'd10415
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic [3:0]  PADDR,
    input  logic [31:0] PWDATA,
    input  logic        PWRITE,
    input  logic        PENABLE,
    input  logic        PSEL,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    input  logic        rx,
    output logic        tx
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    // APB handshake: first access cycle schedules PREADY, the PREADY cycle commits
    logic access, commit;
    logic wr_usr, wr_utd, wr_div, rd_urd;
    assign access = PSEL & PENABLE & ~PREADY;
    assign commit = PSEL & PENABLE & PREADY;
    assign wr_usr = commit &  PWRITE & (PADDR[3:2] == 2'd0);
    assign wr_utd = commit &  PWRITE & (PADDR[3:2] == 2'd1);
    assign wr_div = commit &  PWRITE & (PADDR[3:2] == 2'd3);
    assign rd_urd = commit & ~PWRITE & (PADDR[3:2] == 2'd2);

    logic [15:0]   div_q;
    logic [7:0]    rxd;
    logic          rx_valid, overrun, frame_err;
    logic          tx_full, fifo_empty, tx_empty, tx_pop, push;
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    state_t        tx_state, rx_state;
    logic [15:0]   tx_cnt, rx_cnt;
    logic [7:0]    tx_sh, rx_sh;
    logic [2:0]    tx_bit, rx_bit;
    logic          rx_meta, rx_s;
    logic [31:0]   rdata;

    // Read multiplexer for the register addressed during the access cycle
    always_comb begin
        // NOTE: default first so every path assigns rdata and no latch is inferred.
        rdata = '0;
        case (PADDR[3:2])
            2'd0:    rdata[4:0]  = {frame_err, overrun, rx_valid, tx_empty, tx_full};
            2'd2:    rdata[7:0]  = rxd;
            2'd3:    rdata[15:0] = div_q;
            default: rdata       = '0;
        endcase
    end

    // Registered APB response: one wait state, PRDATA zero outside PREADY
    always_ff @(posedge PCLK) begin
        // NOTE: non-blocking assignments for all clocked state so every register
        // samples pre-edge values regardless of statement order.
        if (PRESET) begin
            PREADY <= 1'b0;
            PRDATA <= '0;
        end else begin
            PREADY <= access;
            PRDATA <= access ? rdata : '0;
        end
    end

    // Divisor register
    always_ff @(posedge PCLK) begin
        if (PRESET)      div_q <= DIV_RESET;
        else if (wr_div) div_q <= PWDATA[15:0];
    end

    // TX FIFO control; a push while full is accepted only if the head pops now
    assign tx_full    = (count == FULL_CNT);
    assign fifo_empty = (count == '0);
    assign tx_pop     = ~fifo_empty &
                        ((tx_state == S_IDLE) | ((tx_state == S_STOP) & (tx_cnt == 16'd0)));
    assign push       = wr_utd & (~tx_full | tx_pop);
    assign tx_empty   = fifo_empty & (tx_state == S_IDLE);

    // FIFO storage
    always_ff @(posedge PCLK) begin
        // NOTE: storage is deliberately not reset; pointers and count define validity.
        if (push) fifo_mem[wr_ptr] <= PWDATA[7:0];
    end

    // FIFO pointers and occupancy
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)   wr_ptr <= wr_ptr + 1'b1;
            if (tx_pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, tx_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // TX state machine; STOP chains straight into the next START when data waits
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            tx_state <= S_IDLE;
            tx       <= 1'b1;
            tx_cnt   <= '0;
            tx_sh    <= '0;
            tx_bit   <= '0;
        end else begin
            case (tx_state)
                S_IDLE: begin
                    tx <= 1'b1;
                    if (tx_pop) begin
                        tx_sh    <= fifo_mem[rd_ptr];
                        tx       <= 1'b0;
                        tx_cnt   <= div_q;
                        tx_state <= S_START;
                    end
                end
                S_START: begin
                    if (tx_cnt == 16'd0) begin
                        tx       <= tx_sh[0];
                        tx_cnt   <= div_q;
                        tx_bit   <= '0;
                        tx_state <= S_DATA;
                    end else begin
                        tx_cnt <= tx_cnt - 16'd1;
                    end
                end
                S_DATA: begin
                    if (tx_cnt == 16'd0) begin
                        tx_cnt <= div_q;
                        if (tx_bit == 3'd7) begin
                            tx       <= 1'b1;
                            tx_state <= S_STOP;
                        end else begin
                            tx     <= tx_sh[1];
                            tx_sh  <= tx_sh >> 1;
                            tx_bit <= tx_bit + 3'd1;
                        end
                    end else begin
                        tx_cnt <= tx_cnt - 16'd1;
                    end
                end
                default: begin // S_STOP
                    if (tx_cnt == 16'd0) begin
                        if (tx_pop) begin
                            tx_sh    <= fifo_mem[rd_ptr];
                            tx       <= 1'b0;
                            tx_cnt   <= div_q;
                            tx_state <= S_START;
                        end else begin
                            tx_state <= S_IDLE;
                        end
                    end else begin
                        tx_cnt <= tx_cnt - 16'd1;
                    end
                end
            endcase
        end
    end

    // Two-flop synchroniser for the asynchronous serial input
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    logic [16:0] div_p1;
    logic [15:0] half;
    logic        stop_sample;
    assign div_p1      = {1'b0, div_q} + 17'd1;
    assign half        = div_p1[16:1];
    assign stop_sample = (rx_state == S_STOP) & (rx_cnt == 16'd0);

    // RX state machine: mid-start check, then one sample per bit period
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            rx_state <= S_IDLE;
            rx_cnt   <= '0;
            rx_sh    <= '0;
            rx_bit   <= '0;
        end else begin
            case (rx_state)
                S_IDLE: begin
                    if (!rx_s) begin
                        rx_cnt   <= half;
                        rx_state <= S_START;
                    end
                end
                S_START: begin
                    if (rx_cnt <= 16'd1) begin
                        if (!rx_s) begin
                            rx_cnt   <= div_q;
                            rx_bit   <= '0;
                            rx_state <= S_DATA;
                        end else begin
                            rx_state <= S_IDLE;
                        end
                    end else begin
                        rx_cnt <= rx_cnt - 16'd1;
                    end
                end
                S_DATA: begin
                    if (rx_cnt == 16'd0) begin
                        rx_sh  <= {rx_s, rx_sh[7:1]};
                        rx_cnt <= div_q;
                        if (rx_bit == 3'd7) rx_state <= S_STOP;
                        else                rx_bit   <= rx_bit + 3'd1;
                    end else begin
                        rx_cnt <= rx_cnt - 16'd1;
                    end
                end
                default: begin // S_STOP
                    if (rx_cnt == 16'd0) rx_state <= S_IDLE;
                    else                 rx_cnt   <= rx_cnt - 16'd1;
                end
            endcase
        end
    end

    // RX holding register and status flags; sets take priority over clears
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            rxd       <= '0;
            rx_valid  <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (wr_usr && PWDATA[3]) overrun   <= 1'b0;
            if (wr_usr && PWDATA[4]) frame_err <= 1'b0;
            if (rd_urd)              rx_valid  <= 1'b0;
            if (stop_sample) begin
                if (!rx_s) begin
                    frame_err <= 1'b1;
                end else if (rx_valid && !rd_urd) begin
                    overrun <= 1'b1;
                end else begin
                    rxd      <= rx_sh;
                    rx_valid <= 1'b1;
                end
            end
        end
    end

    logic unused_bits;
    assign unused_bits = ^{PADDR[1:0], PWDATA[31:16], div_p1[0]};

endmodule

// File: tb/tb_uart_periph.sv
// tb_uart_periph: directed self-checking bench for uart_periph.
module tb_uart_periph;
    logic        PCLK = 1'b0;
    logic        PRESET;
    logic [3:0]  PADDR;
    logic [31:0] PWDATA;
    logic        PWRITE, PENABLE, PSEL;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        rx;
    logic        tx;

    int total = 0;
    int bad   = 0;

    localparam logic [3:0] A_USR = 4'h0, A_UTD = 4'h4, A_URD = 4'h8, A_DIV = 4'hC;

    uart_periph #(.FIFO_DEPTH(4), .DIV_RESET(16'd10415)) dut (
        .PCLK(PCLK), .PRESET(PRESET), .PADDR(PADDR), .PWDATA(PWDATA),
        .PWRITE(PWRITE), .PENABLE(PENABLE), .PSEL(PSEL), .PRDATA(PRDATA),
        .PREADY(PREADY), .rx(rx), .tx(tx)
    );

    always #5 PCLK = ~PCLK;

    // Called just after a clock edge; returns just after the commit edge.
    task automatic apb_write(input logic [3:0] a, input logic [31:0] d);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
        @(posedge PCLK); #1; PENABLE = 1'b1;
        @(posedge PCLK); #1;
        @(posedge PCLK); #1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [3:0] a, output logic [31:0] d);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
        @(posedge PCLK); #1; PENABLE = 1'b1;
        @(posedge PCLK); #1; d = PRDATA;
        @(posedge PCLK); #1; PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    // Drive one serial frame with period p cycles per bit.
    task automatic send_rx(input logic [7:0] b, input logic stop_bit, input int p);
        logic [9:0] fr;
        fr = {stop_bit, b, 1'b0};
        for (int j = 0; j < 10; j++) begin
            rx = fr[j];
            repeat (p) @(posedge PCLK);
            #1;
        end
        rx = 1'b1;
    endtask

    function automatic logic frame_bit(input logic [7:0] b, input int j);
        if (j == 0) return 1'b0;
        if (j == 9) return 1'b1;
        return b[j-1];
    endfunction

    task automatic test_reset;
        logic [31:0] d;
        PRESET = 1'b1;
        repeat (2) @(posedge PCLK);
        #1;
        total++; if (tx !== 1'b1)    begin bad++; $display("FAIL reset_tx got=%b exp=1", tx); end
        total++; if (PREADY !== 1'b0) begin bad++; $display("FAIL reset_pready got=%b exp=0", PREADY); end
        total++; if (PRDATA !== 32'h0) begin bad++; $display("FAIL reset_prdata got=%h exp=0", PRDATA); end
        PRESET = 1'b0;
        @(posedge PCLK); #1;
        // hand-driven USR read observing the handshake cycle by cycle
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = A_USR;
        @(posedge PCLK); #1; PENABLE = 1'b1;
        total++; if (PREADY !== 1'b0) begin bad++; $display("FAIL hs_access1_pready got=%b exp=0", PREADY); end
        total++; if (PRDATA !== 32'h0) begin bad++; $display("FAIL hs_access1_prdata got=%h exp=0", PRDATA); end
        @(posedge PCLK); #1;
        total++; if (PREADY !== 1'b1) begin bad++; $display("FAIL hs_access2_pready got=%b exp=1", PREADY); end
        total++; if (PRDATA !== 32'h2) begin bad++; $display("FAIL reset_usr got=%h exp=2", PRDATA); end
        @(posedge PCLK); #1; PSEL = 1'b0; PENABLE = 1'b0;
        total++; if (PREADY !== 1'b0) begin bad++; $display("FAIL hs_after_pready got=%b exp=0", PREADY); end
        total++; if (PRDATA !== 32'h0) begin bad++; $display("FAIL hs_after_prdata got=%h exp=0", PRDATA); end
        apb_read(A_DIV, d);
        total++; if (d !== 32'd10415) begin bad++; $display("FAIL reset_div got=%0d exp=10415", d); end
    endtask

    task automatic test_single_tx;
        logic [31:0] d;
        int errs;
        apb_write(A_DIV, 32'd3);
        apb_read(A_DIV, d);
        total++; if (d !== 32'd3) begin bad++; $display("FAIL div_rw got=%0d exp=3", d); end
        apb_write(A_UTD, 32'hA5);
        total++; if (tx !== 1'b1) begin bad++; $display("FAIL tx_latency_early got=%b exp=1", tx); end
        errs = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge PCLK); #1;
            total++;
            if (tx !== frame_bit(8'hA5, i / 4)) begin
                bad++; errs++;
                if (errs < 4) $display("FAIL tx_a5_cycle%0d got=%b exp=%b", i, tx, frame_bit(8'hA5, i / 4));
            end
        end
        @(posedge PCLK); #1;
        total++; if (tx !== 1'b1) begin bad++; $display("FAIL tx_a5_idle got=%b exp=1", tx); end
        apb_read(A_USR, d);
        total++; if (d !== 32'h2) begin bad++; $display("FAIL tx_a5_usr got=%h exp=2", d); end
    endtask

    task automatic test_div_zero;
        logic [31:0] d;
        apb_write(A_DIV, 32'd0);
        apb_write(A_UTD, 32'h96);
        total++; if (tx !== 1'b1) begin bad++; $display("FAIL div0_early got=%b exp=1", tx); end
        for (int i = 0; i < 10; i++) begin
            @(posedge PCLK); #1;
            total++;
            if (tx !== frame_bit(8'h96, i)) begin
                bad++; $display("FAIL div0_bit%0d got=%b exp=%b", i, tx, frame_bit(8'h96, i));
            end
        end
        @(posedge PCLK); #1;
        total++; if (tx !== 1'b1) begin bad++; $display("FAIL div0_idle got=%b exp=1", tx); end
        apb_read(A_USR, d);
        total++; if (d !== 32'h2) begin bad++; $display("FAIL div0_usr got=%h exp=2", d); end
        apb_write(A_DIV, 32'd3);
    endtask

    task automatic test_fifo_full;
        logic [7:0]  bytes [5];
        logic [31:0] d;
        bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33; bytes[3] = 8'h44; bytes[4] = 8'h55;
        fork
            begin
                for (int k = 1; k <= 6; k++) apb_write(A_UTD, 32'(k * 17));
                apb_read(A_USR, d);
                total++; if (d !== 32'h1) begin bad++; $display("FAIL fifo_full_usr got=%h exp=1", d); end
            end
            begin
                int waited;
                int errs;
                waited = 0;
                while (tx !== 1'b0 && waited < 20) begin
                    @(posedge PCLK); #1; waited++;
                end
                total++;
                if (tx !== 1'b0) begin
                    bad++; $display("FAIL fifo_tx_start got=%b exp=0 within 20 cycles", tx);
                end else begin
                    errs = 0;
                    for (int i = 0; i < 200; i++) begin
                        if (i > 0) begin @(posedge PCLK); #1; end
                        total++;
                        if (tx !== frame_bit(bytes[i / 40], (i % 40) / 4)) begin
                            bad++; errs++;
                            if (errs < 4) $display("FAIL fifo_stream_cycle%0d got=%b exp=%b",
                                                   i, tx, frame_bit(bytes[i / 40], (i % 40) / 4));
                        end
                    end
                    errs = 0;
                    for (int i = 0; i < 50; i++) begin
                        @(posedge PCLK); #1;
                        if (tx !== 1'b1) errs++;
                    end
                    total++;
                    if (errs != 0) begin bad++; $display("FAIL fifo_dropped_sixth low_cycles=%0d exp=0", errs); end
                end
            end
        join
        apb_read(A_USR, d);
        total++; if (d !== 32'h2) begin bad++; $display("FAIL fifo_drain_usr got=%h exp=2", d); end
    endtask

    task automatic test_rx_overrun;
        logic [31:0] d;
        send_rx(8'h3C, 1'b1, 4);
        repeat (10) @(posedge PCLK);
        #1;
        send_rx(8'hC3, 1'b1, 4);
        repeat (10) @(posedge PCLK);
        #1;
        apb_read(A_USR, d);
        total++; if (d !== 32'hE) begin bad++; $display("FAIL rx_overrun_usr got=%h exp=e", d); end
        apb_read(A_URD, d);
        total++; if (d !== 32'h3C) begin bad++; $display("FAIL rx_urd got=%h exp=3c", d); end
        apb_read(A_USR, d);
        total++; if (d !== 32'hA) begin bad++; $display("FAIL rx_valid_clear got=%h exp=a", d); end
        apb_write(A_USR, 32'h8);
        apb_read(A_USR, d);
        total++; if (d !== 32'h2) begin bad++; $display("FAIL rx_w1c_overrun got=%h exp=2", d); end
    endtask

    task automatic test_rx_frame_glitch;
        logic [31:0] d;
        send_rx(8'h55, 1'b0, 4);
        repeat (10) @(posedge PCLK);
        #1;
        apb_read(A_USR, d);
        total++; if (d !== 32'h12) begin bad++; $display("FAIL rx_frame_err got=%h exp=12", d); end
        apb_write(A_USR, 32'h10);
        apb_read(A_USR, d);
        total++; if (d !== 32'h2) begin bad++; $display("FAIL rx_w1c_frame got=%h exp=2", d); end
        rx = 1'b0;
        @(posedge PCLK); #1;
        rx = 1'b1;
        repeat (5) @(posedge PCLK);
        #1;
        apb_read(A_USR, d);
        total++; if (d !== 32'h2) begin bad++; $display("FAIL rx_glitch_usr got=%h exp=2", d); end
        send_rx(8'h81, 1'b1, 4);
        repeat (10) @(posedge PCLK);
        #1;
        apb_read(A_USR, d);
        total++; if (d !== 32'h6) begin bad++; $display("FAIL rx_after_glitch_usr got=%h exp=6", d); end
        apb_read(A_URD, d);
        total++; if (d !== 32'h81) begin bad++; $display("FAIL rx_after_glitch_urd got=%h exp=81", d); end
    endtask

    task automatic test_reset_mid_tx;
        logic [31:0] d;
        int lows;
        apb_write(A_UTD, 32'h00);
        apb_write(A_UTD, 32'h0F);
        repeat (6) @(posedge PCLK);
        #1;
        total++; if (tx !== 1'b0) begin bad++; $display("FAIL midtx_in_data got=%b exp=0", tx); end
        PRESET = 1'b1;
        @(posedge PCLK); #1;
        total++; if (tx !== 1'b1) begin bad++; $display("FAIL midtx_reset_tx got=%b exp=1", tx); end
        PRESET = 1'b0;
        lows = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge PCLK); #1;
            if (tx !== 1'b1) lows++;
        end
        total++; if (lows != 0) begin bad++; $display("FAIL midtx_no_frame low_cycles=%0d exp=0", lows); end
        apb_read(A_USR, d);
        total++; if (d !== 32'h2) begin bad++; $display("FAIL midtx_usr got=%h exp=2", d); end
        apb_read(A_DIV, d);
        total++; if (d !== 32'd10415) begin bad++; $display("FAIL midtx_div got=%0d exp=10415", d); end
    endtask

    initial begin
        PRESET = 1'b1; PADDR = '0; PWDATA = '0; PWRITE = 1'b0;
        PENABLE = 1'b0; PSEL = 1'b0; rx = 1'b1;
        test_reset;
        test_single_tx;
        test_div_zero;
        test_fifo_full;
        test_rx_overrun;
        test_rx_frame_glitch;
        apb_write(A_DIV, 32'd3);
        test_reset_mid_tx;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_periph.md
# uart_periph

APB slave UART for the RV32I MCU, hung off a spare `PSELn`/`PRDATAn`/`PREADYn` slot of `APB_Master` beside the GPIO and FND peripherals. It serialises CPU-written bytes through a 4-entry TX FIFO onto `tx`. It deserialises `rx` into a single holding register with overrun and framing flags. The bit period is programmable through a divisor register.

## Interface
- Parameters:
- `FIFO_DEPTH`, default 4: TX FIFO entries (power of two).
- `DIV_RESET`, default 10415: reset divisor (100 MHz → 9600 baud).
- Ports:
- `PCLK`  in  1  system clock; all logic on rising edge.
- `PRESET`  in  1  reset, synchronous, active-high.
- `PADDR`  in  4  byte address; `PADDR[3:2]` selects the register.
- `PWDATA`  in  32  write data.
- `PWRITE`  in  1  1 = write, 0 = read.
- `PENABLE`  in  1  APB access phase.
- `PSEL`  in  1  slave select.
- `PRDATA`  out  32  read data, valid while `PREADY` = 1.
- `PREADY`  out  1  transfer complete.
- `rx`  in  1  serial input, asynchronous.
- `tx`  out  1  serial output, idle high.

## Operation
- Register map:
- 0x0 USR: status register.
  - Read fields: [0] `tx_full`; [1] `tx_empty` (FIFO empty and shifter idle); [2] `rx_valid`; [3] `overrun`; [4] `frame_err`; other bits 0.
  - Write: 1 to bit 3 or bit 4 clears that flag (W1C); bits 0–2 ignored.
- 0x4 UTD: write pushes `PWDATA[7:0]` into the FIFO.
  - A write while full is dropped and the FIFO is unchanged.
  - Read returns 0.
- 0x8 URD: read returns `{24'b0, rxd}` and clears `rx_valid`. Writes are ignored.
- 0xC DIV: divisor, [15:0] read/write. Bit period is DIV+1 `PCLK` cycles.
- Baud rules:
  - The divisor value 0 is legal and gives 1 cycle per bit.
  - A DIV write takes effect at the next bit-counter reload; software changes DIV only while idle.
- TX state machine: IDLE → START → DATA → STOP → IDLE.
  - IDLE: `tx` = 1. If the FIFO is non-empty, pop the head into the shifter and go to START.
  - START: `tx` = 0 for DIV+1 cycles.
  - DATA: 8 bits, LSB first, each held DIV+1 cycles.
  - STOP: `tx` = 1 for DIV+1 cycles. Then IDLE, which can pop again in the same cycle.
  - Back-to-back frames have no extra idle gap.
- RX path:
  - `rx` passes through a 2-flop synchroniser, giving `rx_s`.
  - IDLE: on `rx_s` = 0 go to START.
  - START: wait (DIV+1)/2 cycles, integer floor. If `rx_s` is still 0, go to DATA; otherwise this is a false start and the FSM returns to IDLE.
  - DATA: sample `rx_s` every DIV+1 cycles; 8 samples, LSB first.
  - STOP: after a further DIV+1 cycles, sample the stop bit.
- RX frame completion:
  - Stop = 1 and `rx_valid` = 0: load `rxd` and set `rx_valid`.
  - Stop = 1 and `rx_valid` = 1: set `overrun`; `rxd` keeps the old byte.
  - Stop = 0: set `frame_err`; discard the byte.
  - In every case the FSM returns to IDLE.
- Simultaneous events:
  - An RX load and a URD read in the same cycle: the new byte is loaded and `rx_valid` stays 1. No overrun.
  - A UTD push and a TX pop in the same cycle while full: the push is accepted.
  - A W1C clear and a flag set in the same cycle: the set wins.

## Timing
- APB protocol:
  - Setup cycle: `PSEL` = 1, `PENABLE` = 0.
  - First access cycle: `PSEL` = `PENABLE` = 1 and `PREADY` = 0.
  - The next cycle is registered and has `PREADY` = 1 with `PRDATA` valid. Each transfer therefore has one wait state.
  - `PREADY` is high for exactly one cycle per transfer.
  - The write commit and all read side effects (URD clear, W1C) occur on the edge ending the `PREADY` = 1 cycle.
- `PRDATA` = 0 whenever `PREADY` = 0.
- TX latency: a UTD write completes at cycle N. With the FIFO empty and TX idle, `tx` falls at N+2 (push at N+1, pop at N+2).
- RX latency: `rx_valid` rises 2 (synchroniser) + (DIV+1)/2 + 9·(DIV+1) + 1 cycles after the falling edge of `rx`.
- Reset values (synchronous, highest priority):
  - Outputs: `tx` = 1, `PREADY` = 0, `PRDATA` = 0.
  - Internal state: FIFO empty, both FSMs IDLE, DIV = `DIV_RESET`, `rxd` = 0, all flags 0.
- Reset mid-frame aborts the frame, forcing `tx` = 1 on the next edge.

## Test plan
- Reset and idle status: assert `PRESET` for 2 cycles. Then `tx` = 1, USR reads 0x2, DIV reads 10415, and each APB read shows `PREADY` on the second access cycle only.
- Single TX frame: DIV = 3, write UTD = 0xA5.
  - `tx` = 0 starting 2 cycles after the transfer.
  - Data bits are 1,0,1,0,0,1,0,1, each 4 cycles, then stop = 1.
  - Frame is 40 cycles; USR[1] returns to 1.
- FIFO full: DIV = 3, write 0x11, 0x22, 0x33, 0x44, 0x55, 0x66 back to back.
  - USR[0] = 1 after the sixth write, which is dropped (first byte already in the shifter, 4 in the FIFO).
  - Five frames appear contiguously with no idle gap: 0x11–0x55.
- RX good and overrun: DIV = 3, drive frames 0x3C then 0xC3 with no URD read in between.
  - USR = 0xE, i.e. bits [3:1] set.
  - URD reads 0x3C and clears `rx_valid`.
  - W1C 0x8 clears the overrun flag.
- RX framing error and glitch:
  - Frame 0x55 with stop = 0: `frame_err` = 1, `rx_valid` = 0.
  - A 1-cycle low glitch on `rx`: no flags change and the RX FSM is back in IDLE within 5 cycles.
- Reset mid-TX: `PRESET` during DATA of 0x00. `tx` = 1 on the next edge, the FIFO is empty, and no further frame is sent.
